instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//   Encodes LEGv8 instructions from decoded fields (class, Rd/Rt, Rn, Rm, imm) into 32-bit words,
//   the inverse of the opcode-to-control decode. Writes each word sequentially into instruction memory.
//   Sits between the bench/boot host and instruction memory; loads programs before the core runs.
// PARAMETERS
//   ADDR_W     6   instruction-memory word-address width (depth 2**ADDR_W words)
//   BASE_ADDR  0   word address of the first instruction written after reset/start
// PORTS
//   clk         in   1        rising-edge clock
//   reset       in   1        asynchronous, active-high reset
//   start       in   1        1-cycle pulse: restart load at BASE_ADDR, clear count and err
//   in_valid    in   1        instruction fields valid
//   in_ready    out  1        encoder can accept fields this cycle
//   in_op       in   3        0 ADD,1 SUB,2 AND,3 ORR,4 LDUR,5 STUR,6 CBZ,7 reserved
//   in_rd       in   5        Rd (R-format) / Rt (LDUR, STUR, CBZ)
//   in_rn       in   5        Rn (R-format, LDUR, STUR)
//   in_rm       in   5        Rm (R-format only)
//   in_imm      in   19       signed immediate: DT_address (D) or COND_BR_address (CB)
//   imem_we     out  1        instruction-memory write strobe
//   imem_addr   out  ADDR_W   write word address
//   imem_wdata  out  32       encoded instruction
//   count       out  ADDR_W+1 number of words written since reset/start
//   full        out  1        count == 2**ADDR_W
//   err         out  1        sticky: illegal op or out-of-range immediate seen
// BEHAVIOUR
//   Reset (async): state=IDLE, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, err=0.
//   Reset mid-operation drops the pending word; imem_we deasserts immediately.
//   FSM: IDLE -> ENC -> WR -> IDLE.
//   - IDLE: in_ready = !full && !start. Handshake = in_valid && in_ready; fields are sampled.
//     Legal request -> ENC. Illegal request -> err<=1, stays IDLE, no write.
//   - ENC: word built from the registered fields into imem_wdata; in_ready=0; -> WR.
//   - WR: imem_we=1 for exactly one cycle at imem_addr; in_ready=0.
//     On leaving WR: count+=1 and imem_addr+=1 (mod 2**ADDR_W) -> IDLE.
//   Latency: handshake in cycle N -> imem_we high in cycle N+2. Throughput: 1 word per 3 cycles.
//   Encoding (bit ranges of imem_wdata):
//   - R-format (ADD/SUB/AND/ORR): [31:21] = 10001011000 / 11001011000 / 10001010000 / 10101010000,
//     [20:16]=Rm, [15:10]=000000, [9:5]=Rn, [4:0]=Rd. in_imm is ignored.
//   - D-format (LDUR/STUR): [31:21] = 11111000010 (LDUR) / 11111000000 (STUR),
//     [20:12]=in_imm[8:0], [11:10]=00, [9:5]=Rn, [4:0]=Rt.
//   - CB-format (CBZ): [31:24]=10110100, [23:5]=in_imm[18:0], [4:0]=Rt. in_rn and in_rm are ignored.
//   Illegal request:
//   - in_op==7, or
//   - D-format with in_imm[18:9] not all equal to in_imm[8] (outside the 9-bit signed range).
//   start:
//   - Honoured only in IDLE: next cycle count=0, imem_addr=BASE_ADDR, err=0.
//   - In ENC/WR, start is ignored and not remembered.
//   - start and in_valid in the same IDLE cycle: start wins, the request is not accepted.
//   full:
//   - When count reaches 2**ADDR_W, full=1 and in_ready=0 until start or reset.
//   - imem_addr has wrapped to BASE_ADDR at that point, and no overwrite occurs.
//   err: sticky; does not block later legal requests. Cleared only by start or reset.
// TESTING
//   1 ADD X1,X2,X3 (op0,rd1,rn2,rm3) -> 2 cycles later imem_we=1, addr=0, wdata=0x8B030041, count=1.
//   2 LDUR X5,[X6,#8] (op4,rd5,rn6,imm8) -> wdata=0xF84080C5 at addr 1; in_ready low for 2 cycles.
//   3 CBZ X9,-2 (op6,rd9,imm=0x7FFFE) -> wdata=0xB4FFFFC9; STUR with imm=0x00100 -> err=1, no imem_we, count unchanged.
//   4 ADDR_W=2: four legal writes -> addrs 0..3, count=4, full=1, in_ready=0; in_valid then ignored.
//     Then start -> count=0, full=0, err=0, next write at addr 0.
//   5 start+in_valid same IDLE cycle -> no handshake, count=0; reset asserted during WR -> imem_we=0 at once, count=0.
//   6 op7 request -> err=1, then legal ORR X0,X1,X2 still written (wdata=0xAA020020), err stays 1.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes LEGv8 instruction fields into 32-bit words and writes them
// sequentially into instruction memory (IDLE -> ENC -> WR per word).
module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [4:0]        rn_q;
  logic [4:0]        rm_q;
  logic [18:0]       imm_q;
  logic              handshake_d;

  // D-format offsets must fit in 9 signed bits; op 7 is reserved.
  function automatic logic is_illegal(input logic [2:0] op, input logic [18:0] imm);
    logic d_fmt;
    d_fmt = (op == 3'd4) || (op == 3'd5);
    return (op == 3'd7) || (d_fmt && (imm[18:9] != {10{imm[8]}}));
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] rd,
                                         input logic [4:0] rn, input logic [4:0] rm,
                                         input logic [18:0] imm);
    logic [31:0] w;
    case (op)
      3'd0:    w = {11'b10001011000, rm, 6'b000000, rn, rd};
      3'd1:    w = {11'b11001011000, rm, 6'b000000, rn, rd};
      3'd2:    w = {11'b10001010000, rm, 6'b000000, rn, rd};
      3'd3:    w = {11'b10101010000, rm, 6'b000000, rn, rd};
      3'd4:    w = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      3'd5:    w = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      3'd6:    w = {8'b10110100, imm, rd};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  assign full        = (count_q == DEPTH);
  assign in_ready    = (state_q == S_IDLE) && !full && !start;
  assign handshake_d = in_valid && in_ready;

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

  // Load FSM: sample fields, build the word, then strobe it into memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= 32'd0;
      count_q <= '0;
      err_q   <= 1'b0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      rn_q    <= 5'd0;
      rm_q    <= 5'd0;
      imm_q   <= 19'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          we_q <= 1'b0;
          if (start) begin
            count_q <= '0;
            addr_q  <= BASE;
            err_q   <= 1'b0;
          end else if (handshake_d) begin
            if (is_illegal(in_op, in_imm)) begin
              err_q <= 1'b1;
            end else begin
              op_q    <= in_op;
              rd_q    <= in_rd;
              rn_q    <= in_rn;
              rm_q    <= in_rm;
              imm_q   <= in_imm;
              state_q <= S_ENC;
            end
          end
        end
        S_ENC: begin
          wdata_q <= encode(op_q, rd_q, rn_q, rm_q, imm_q);
          we_q    <= 1'b1;
          state_q <= S_WR;
        end
        S_WR: begin
          we_q    <= 1'b0;
          count_q <= count_q + {{ADDR_W{1'b0}}, 1'b1};
          addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_q <= S_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: a scoreboard of expected
// (address, word) pairs is compared against every imem_we strobe.
module tb_instr_encoder_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'd0;
  logic [4:0]    in_rd = 5'd0;
  logic [4:0]    in_rn = 5'd0;
  logic [4:0]    in_rm = 5'd0;
  logic [18:0]   in_imm = 19'd0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] q_addr[$];
  logic [31:0]   q_data[$];
  logic [AW-1:0] exp_addr = '0;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Reference encoder built from the opcode table with shifts.
  function automatic logic [31:0] model_enc(input int op, input int rd, input int rn,
                                            input int rm, input logic [18:0] imm);
    int opc [6] = '{32'h458, 32'h658, 32'h450, 32'h550, 32'h7C2, 32'h7C0};
    logic [31:0] w;
    if (op < 4)       w = (opc[op] << 21) | (rm << 16) | (rn << 5) | rd;
    else if (op < 6)  w = (opc[op] << 21) | ((32'(imm) & 32'h1FF) << 12) | (rn << 5) | rd;
    else              w = (32'hB4 << 24) | (32'(imm) << 5) | rd;
    return w;
  endfunction

  // Scoreboard: every write strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_checks++;
      if (q_data.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        ea = q_addr.pop_front();
        ed = q_data.pop_front();
        if (imem_addr !== ea || imem_wdata !== ed) begin
          n_errors++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   imem_addr, imem_wdata, ea, ed);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] data);
    q_addr.push_back(exp_addr);
    q_data.push_back(data);
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [18:0] imm);
    int w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (imem_we !== 1'b0 || imem_addr !== 2'd0 || imem_wdata !== 32'd0 ||
        count !== 3'd0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: we=%b addr=%0d wdata=%h count=%0d err=%b, expected 0/0/0/0/0",
               imem_we, imem_addr, imem_wdata, count, err);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || full !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: in_ready=%b full=%b, expected 1/0", in_ready, full);
    end
  endtask

  task automatic test_add_latency();
    push_exp(32'h8B030041);
    issue(3'd0, 5'd1, 5'd2, 5'd3, 19'd0);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || imem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL add_enc_cycle: in_ready=%b we=%b, expected 0/0", in_ready, imem_we);
    end
    @(negedge clk);
    n_checks++;
    if (imem_we !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL add_wr_cycle: we=%b in_ready=%b, expected 1/0", imem_we, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (count !== 3'd1 || imem_we !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL add_done: count=%0d we=%b in_ready=%b, expected 1/0/1", count, imem_we, in_ready);
    end
  endtask

  task automatic test_ldur();
    int busy = 0;
    push_exp(32'hF84080C5);
    issue(3'd4, 5'd5, 5'd6, 5'd0, 19'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready === 1'b0) busy++;
    end
    n_checks++;
    if (busy != 2 || count !== 3'd2) begin
      n_errors++;
      $display("FAIL ldur_busy: busy_cycles=%0d count=%0d, expected 2/2", busy, count);
    end
  endtask

  task automatic test_cbz_and_bad_stur();
    push_exp(32'hB4FFFFC9);
    issue(3'd6, 5'd9, 5'd0, 5'd0, 19'h7FFFE);
    repeat (3) @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || count !== 3'd3) begin
      n_errors++;
      $display("FAIL cbz_done: err=%b count=%0d, expected 0/3", err, count);
    end
    issue(3'd5, 5'd1, 5'd2, 5'd0, 19'h00100);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stur_range_err: err=%b in_ready=%b, expected 1/1", err, in_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (count !== 3'd3) begin
      n_errors++;
      $display("FAIL stur_no_write: count=%0d, expected 3", count);
    end
  endtask

  task automatic test_full();
    int ops [4] = '{0, 4, 6, 3};
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (count !== 3'd0 || err !== 1'b0 || imem_addr !== 2'd0) begin
      n_errors++;
      $display("FAIL start_clear: count=%0d err=%b addr=%0d, expected 0/0/0", count, err, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      logic [4:0]  rd, rn, rm;
      logic [8:0]  i9;
      logic [18:0] imm;
      rd = 5'($urandom); rn = 5'($urandom); rm = 5'($urandom); i9 = 9'($urandom);
      imm = (ops[i] == 4) ? {{10{i9[8]}}, i9} : 19'($urandom);
      push_exp(model_enc(ops[i], int'(rd), int'(rn), int'(rm), imm));
      issue(3'(ops[i]), rd, rn, rm, imm);
      repeat (3) @(negedge clk);
    end
    n_checks++;
    if (count !== 3'd4 || full !== 1'b1 || in_ready !== 1'b0 || imem_addr !== 2'd0) begin
      n_errors++;
      $display("FAIL full_state: count=%0d full=%b in_ready=%b addr=%0d, expected 4/1/0/0",
               count, full, in_ready, imem_addr);
    end
    in_valid = 1'b1; in_op = 3'd0;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd4 || full !== 1'b1) begin
      n_errors++;
      $display("FAIL full_ignores_valid: count=%0d full=%b, expected 4/1", count, full);
    end
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (count !== 3'd0 || full !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL full_restart: count=%0d full=%b err=%b in_ready=%b, expected 0/0/0/1",
               count, full, err, in_ready);
    end
    push_exp(model_enc(1, 7, 8, 9, 19'd0));
    issue(3'd1, 5'd7, 5'd8, 5'd9, 19'd0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (count !== 3'd1) begin
      n_errors++;
      $display("FAIL after_restart: count=%0d, expected 1", count);
    end
  endtask

  task automatic test_start_collision_and_reset();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_op = 3'd0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL collision_ready: in_ready=%b, expected 0", in_ready);
    end
    @(posedge clk);
    #1 start = 1'b0; in_valid = 1'b0;
    exp_addr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (count !== 3'd0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL collision_no_hs: count=%0d in_ready=%b, expected 0/1", count, in_ready);
    end
    push_exp(model_enc(2, 3, 4, 5, 19'd0));
    issue(3'd2, 5'd3, 5'd4, 5'd5, 19'd0);
    repeat (3) @(negedge clk);
    issue(3'd0, 5'd1, 5'd1, 5'd1, 19'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (imem_we !== 1'b0 || count !== 3'd0 || imem_addr !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_in_wr: we=%b count=%0d addr=%0d, expected 0/0/0", imem_we, count, imem_addr);
    end
    @(negedge clk) reset = 1'b0;
    exp_addr = '0;
  endtask

  task automatic test_op7_then_orr();
    issue(3'd7, 5'd1, 5'd2, 5'd3, 19'd0);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || count !== 3'd0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL op7_err: err=%b count=%0d in_ready=%b, expected 1/0/1", err, count, in_ready);
    end
    repeat (2) @(negedge clk);
    push_exp(32'hAA020020);
    issue(3'd3, 5'd0, 5'd1, 5'd2, 19'd0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || count !== 3'd1) begin
      n_errors++;
      $display("FAIL orr_after_err: err=%b count=%0d, expected 1/1", err, count);
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_ldur();
    test_cbz_and_bad_stur();
    test_full();
    test_start_collision_and_reset();
    test_op7_then_orr();
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_data.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d writes missing, expected 0", q_data.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
